// File: rtl/pll_reset_supervisor.sv
// PLL reset supervisor: sequences the PLL reset from the board reference clock,
// qualifies lock for a stable period, then releases the system reset. It
// re-sequences on lock loss or software request and parks in FAIL after a
// bounded number of lock timeouts.
module pll_reset_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sw_relock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       lock_lost,
    output logic       fail,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAIL
    } state_t;

    // Terminal counts: compare against parameter-1 so the counter never wraps.
    localparam logic [31:0] RST_LAST     = 32'(RST_PULSE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

    logic        meta_q;
    logic        locked_s_q;
    logic        locked_s;

    state_t      state_q,     state_d;
    logic [31:0] cnt_q,       cnt_d;
    logic [3:0]  retry_q,     retry_d;
    logic        lost_q,      lost_d;
    logic        pll_rst_q,   pll_rst_d;
    logic        sys_rst_n_q, sys_rst_n_d;
    logic        fail_q,      fail_d;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            meta_q     <= pll_locked;
            locked_s_q <= meta_q;
        end
    end

    assign locked_s = locked_s_q;

    // Next-state, counter and sticky status; outputs decode from the next state
    // so they are registered alongside it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        retry_d = retry_q;
        lost_d  = lost_q;
        unique case (state_q)
            S_RESET_PLL: begin
                if (sw_relock) begin
                    cnt_d = '0;
                end else if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (sw_relock) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                end else if (locked_s) begin
                    state_d = S_STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_RESET_PLL;
                        retry_d = retry_q + 4'd1;
                    end
                end
            end
            S_STABILIZE: begin
                if (sw_relock) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                end else if (!locked_s) begin
                    // Glitch during qualification: restart the lock wait without
                    // charging it as a retry.
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                // Lock drop wins over a coincident software request.
                if (!locked_s) begin
                    state_d = S_RESET_PLL;
                    lost_d  = 1'b1;
                    retry_d = '0;
                end else if (sw_relock) begin
                    state_d = S_RESET_PLL;
                    retry_d = '0;
                end
            end
            S_FAIL: begin
                cnt_d = '0;
                if (sw_relock) begin
                    state_d = S_RESET_PLL;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase
        pll_rst_d   = (state_d == S_RESET_PLL);
        sys_rst_n_d = (state_d == S_RUN);
        fail_d      = (state_d == S_FAIL);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            lost_q      <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign lock_lost   = lost_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Bench for pll_reset_supervisor: a table of timed input segments whose
// expected outputs go into a scoreboard keyed by cycle, plus hand sequences
// for asynchronous reset, lock loss recovery and the FAIL path.
module tb_pll_reset_supervisor;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_relock = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_lost;
    logic       fail;
    logic [3:0] retry_count;

    pll_reset_supervisor #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(100),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .sw_relock  (sw_relock),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .lock_lost  (lock_lost),
        .fail       (fail),
        .retry_count(retry_count)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic       prst;
        logic       srst_n;
        logic       lost;
        logic       fl;
        logic [3:0] retry;
    } out_t;

    typedef struct {
        string name;
        logic  rst;
        logic  lk;
        logic  rl;
        int    hold;
        out_t  exp;
    } vec_t;

    typedef struct {
        int    due;
        string name;
        out_t  exp;
    } sb_t;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];
    vec_t tbl[$];

    always @(posedge refclk) cyc <= cyc + 1;

    function automatic out_t mk(logic p, logic s, logic l, logic f, logic [3:0] r);
        out_t o;
        o.prst = p; o.srst_n = s; o.lost = l; o.fl = f; o.retry = r;
        return o;
    endfunction

    function automatic out_t cur();
        out_t o;
        o = {pll_rst, sys_rst_n, lock_lost, fail, retry_count};
        return o;
    endfunction

    task automatic compare(string nm, out_t got, out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (prst,srst_n,lost,fail,retry)", nm, got, exp);
        end
    endtask

    // Expected outputs after 'after' more rising edges, checked on that negedge.
    task automatic push(string nm, int after, out_t e);
        sb_t s;
        s.due = cyc + after; s.name = nm; s.exp = e;
        sb.push_back(s);
    endtask

    task automatic checker_loop();
        forever begin
            @(negedge refclk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    compare(sb[i].name, cur(), sb[i].exp);
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic add(string nm, logic r, logic lk, logic rl, int hold, out_t e);
        vec_t v;
        v.name = nm; v.rst = r; v.lk = lk; v.rl = rl; v.hold = hold; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        // Reset, first lock
        add("reset_state",    0, 0, 0,  3, mk(1,0,0,0,0));
        add("t1_prst_1",      1, 0, 0,  1, mk(1,0,0,0,0));
        add("t1_prst_3",      1, 0, 0,  2, mk(1,0,0,0,0));
        add("t1_prst_fall",   1, 0, 0,  1, mk(0,0,0,0,0));
        add("t1_wait",        1, 0, 0, 16, mk(0,0,0,0,0));
        add("t1_stab_edge9",  1, 1, 0, 10, mk(0,0,0,0,0));
        add("t1_run_edge10",  1, 1, 0,  1, mk(0,1,0,0,0));
        // Software relock in RUN with lock held: lock_lost stays clear
        add("t5_relock_run",  1, 1, 1,  1, mk(1,0,0,0,0));
        add("t5_rst_hold",    1, 1, 0,  3, mk(1,0,0,0,0));
        add("t5_wait",        1, 1, 0,  1, mk(0,0,0,0,0));
        add("t5_stab",        1, 1, 0,  1, mk(0,0,0,0,0));
        add("t5_stab_end",    1, 1, 0,  7, mk(0,0,0,0,0));
        add("t5_run",         1, 1, 0,  1, mk(0,1,0,0,0));
        // Lock drop and relock reach the FSM together
        add("t5_drop_pre",    1, 0, 0,  2, mk(0,1,0,0,0));
        add("t5_drop_relock", 1, 0, 1,  1, mk(1,0,1,0,0));
        // Three timeouts then FAIL
        add("t2_wait0",       1, 0, 0,  4, mk(0,0,1,0,0));
        add("t2_to0_pre",     1, 0, 0, 99, mk(0,0,1,0,0));
        add("t2_to0",         1, 0, 0,  1, mk(1,0,1,0,1));
        add("t2_pulse1",      1, 0, 0,  3, mk(1,0,1,0,1));
        add("t2_wait1",       1, 0, 0,  1, mk(0,0,1,0,1));
        add("t2_to1_pre",     1, 0, 0, 99, mk(0,0,1,0,1));
        add("t2_to1",         1, 0, 0,  1, mk(1,0,1,0,2));
        add("t2_wait2",       1, 0, 0,  4, mk(0,0,1,0,2));
        add("t2_to2_pre",     1, 0, 0, 99, mk(0,0,1,0,2));
        add("t2_fail",        1, 0, 0,  1, mk(0,0,1,1,2));
        add("t2_fail_hold",   1, 0, 0, 20, mk(0,0,1,1,2));
        add("t2_fail_relock", 1, 0, 1,  1, mk(1,0,1,0,0));
        // One timeout, then a lock glitch in STABILIZE keeps retry_count
        add("t3_to",          1, 0, 0,104, mk(1,0,1,0,1));
        add("t3_wait",        1, 0, 0,  4, mk(0,0,1,0,1));
        add("t3_lock",        1, 1, 0,  2, mk(0,0,1,0,1));
        add("t3_stab5",       1, 1, 0,  6, mk(0,0,1,0,1));
        add("t3_glitch",      1, 0, 0,  1, mk(0,0,1,0,1));
        add("t3_relock_pre",  1, 1, 0, 10, mk(0,0,1,0,1));
        add("t3_run",         1, 1, 0,  1, mk(0,1,1,0,1));
        add("t5_relock_lost", 1, 1, 1,  1, mk(1,0,1,0,0));

        fork
            checker_loop();
        join_none

        @(negedge refclk);
        foreach (tbl[i]) begin
            rst_n      = tbl[i].rst;
            pll_locked = tbl[i].lk;
            sw_relock  = tbl[i].rl;
            push(tbl[i].name, tbl[i].hold, tbl[i].exp);
            @(negedge refclk);
            sw_relock = 1'b0;
            repeat (tbl[i].hold - 1) @(negedge refclk);
        end

        // Asynchronous reset while in STABILIZE
        push("t6_in_stab", 8, mk(0,0,1,0,0));
        repeat (8) @(negedge refclk);
        #2 rst_n = 1'b0;
        #1 compare("t6_async_stab", cur(), mk(1,0,0,0,0));
        @(negedge refclk);
        rst_n = 1'b1;
        push("t6_relock_stab", 12, mk(0,0,0,0,0));
        push("t6_relock_run",  13, mk(0,1,0,0,0));
        repeat (13) @(negedge refclk);

        // Lock loss in RUN, then recovery keeps lock_lost
        pll_locked = 1'b0;
        push("t4_loss_edge1", 2, mk(0,1,0,0,0));
        push("t4_loss_edge2", 3, mk(1,0,1,0,0));
        repeat (3) @(negedge refclk);
        pll_locked = 1'b1;
        push("t4_recover_pre", 12, mk(0,0,1,0,0));
        push("t4_recover_run", 13, mk(0,1,1,0,0));
        repeat (13) @(negedge refclk);

        // Drive into FAIL, then asynchronous reset out of it
        pll_locked = 1'b0;
        push("t6_fail_pre", 314, mk(0,0,1,0,2));
        push("t6_fail",     315, mk(0,0,1,1,2));
        repeat (318) @(negedge refclk);
        #2 rst_n = 1'b0;
        #1 compare("t6_async_fail", cur(), mk(1,0,0,0,0));
        repeat (2) @(negedge refclk);

        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: never checked, required %b", sb[i].name, sb[i].exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_supervisor.md
# pll_reset_supervisor

Controls the clocking PLL from the system side: it drives the PLL's active-high reset, watches its `locked` output, and issues the design-wide system reset only after lock has been stable for a programmed time. It re-sequences the PLL on lock loss or on software request, and gives up after a bounded number of lock timeouts. It runs on the 50 MHz board reference clock that also feeds the PLL, so it never depends on a PLL output clock.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, 1000000: cycles allowed in WAIT_LOCK before an attempt fails (20 ms at 50 MHz).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before releasing system reset (≥1).
- `MAX_RETRIES`, 3: extra attempts after the first timeout before FAIL (0–15).

Ports:
- `refclk` in 1: reference clock, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL `locked`, asynchronous to `refclk`.
- `sw_relock` in 1: single-cycle request to re-sequence the PLL.
- `pll_rst` out 1: PLL reset, active high.
- `sys_rst_n` out 1: system reset, active low; high only in RUN.
- `lock_lost` out 1: sticky; set when lock drops in RUN.
- `fail` out 1: high only in FAIL.
- `retry_count` out 4: timeouts in the current sequence.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to form `locked_s`. All FSM decisions use `locked_s`, and all outputs are registered.
- A single cycle counter is cleared on every state change.
- States:
  - **RESET_PLL**: `pll_rst`=1. After `RST_PULSE_CYCLES` cycles, go to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_rst`=0.
    - `locked_s`=1 → STABILIZE.
    - Otherwise, after `LOCK_TIMEOUT_CYCLES` cycles: if `retry_count`==`MAX_RETRIES` → FAIL; else increment `retry_count` and go to RESET_PLL.
  - **STABILIZE**: `locked_s`=0 → WAIT_LOCK, with the timeout counter restarted and no retry increment. After `LOCK_STABLE_CYCLES` consecutive cycles with `locked_s`=1 → RUN.
  - **RUN**: `sys_rst_n`=1.
    - `locked_s`=0 → RESET_PLL, set `lock_lost`, clear `retry_count`.
    - `sw_relock` → RESET_PLL, clear `retry_count`, `lock_lost` unchanged.
  - **FAIL**: `pll_rst`=0, `sys_rst_n`=0, `fail`=1. `sw_relock` → RESET_PLL, clear `retry_count`. Only `sw_relock` or `rst_n` leaves FAIL.
- `sw_relock` in RESET_PLL, WAIT_LOCK or STABILIZE restarts RESET_PLL with the counter cleared and `retry_count` unchanged.
- Simultaneous lock drop and `sw_relock` in RUN: behaves as a lock drop (`lock_lost` set).
- `lock_lost` is cleared only by `rst_n`.
- The counter is 32 bits. The terminal compare is count == parameter−1, so it never wraps.

## Timing
- During and after `rst_n` low:
  - state=RESET_PLL, `pll_rst`=1, `sys_rst_n`=0, `lock_lost`=0, `fail`=0, `retry_count`=0.
  - Synchronizer flops = 0.
- `rst_n` low in mid-operation forces these values immediately (asynchronously), whatever the state.
- `pll_rst` is high for exactly `RST_PULSE_CYCLES` rising edges per attempt. It falls on the edge that enters WAIT_LOCK.
- Lock-acquire latency: take edge 0 as the first edge sampling `pll_locked`=1 in WAIT_LOCK.
  - `locked_s`=1 after edge 1.
  - STABILIZE is entered after edge 2.
  - `sys_rst_n` rises after edge `LOCK_STABLE_CYCLES`+2.
- Lock-loss latency: `pll_locked` falls, first sampled at edge 0 in RUN. `sys_rst_n`=0, `pll_rst`=1 and `lock_lost`=1 all appear after edge 2.
- `sw_relock` sampled high at edge 0: the new state and outputs appear after edge 0.
- A WAIT_LOCK timeout leaves the state on the `LOCK_TIMEOUT_CYCLES`-th edge spent in it.

## Test plan
Bench parameters: `RST_PULSE_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=100, `LOCK_STABLE_CYCLES`=8, `MAX_RETRIES`=2.

1. Release `rst_n`, then raise `pll_locked` 20 cycles later → `pll_rst` is high for 4 edges, `sys_rst_n` rises 10 edges after `pll_locked` is first sampled, `retry_count`=0.
2. Hold `pll_locked`=0 throughout → three 4-cycle `pll_rst` pulses, each 100 cycles apart; `retry_count` steps 1 then 2; `fail`=1 after the third timeout with `pll_rst`=0. A `sw_relock` pulse then clears `fail`, sets `retry_count`=0 and raises `pll_rst`.
3. In STABILIZE, drop `pll_locked` for 1 cycle at stable count 5 → return to WAIT_LOCK, `retry_count` unchanged; a clean lock afterwards reaches RUN 10 edges after it is sampled.
4. In RUN, drop `pll_locked` → after 2 edges `sys_rst_n`=0, `pll_rst`=1, `lock_lost`=1. On relock, `sys_rst_n` returns high and `lock_lost` stays 1.
5. In RUN, pulse `sw_relock` in the same cycle that lock drops → RESET_PLL with `lock_lost`=1. A separate `sw_relock` with lock held → RESET_PLL with `lock_lost` unchanged.
6. Assert `rst_n` low in STABILIZE and in FAIL → all outputs take their reset values without waiting for a clock edge.
